// File: rtl/fib_gen.sv
// Generalised Fibonacci term generator: T(k) = T(k-1) + T(k-2) with run-time seeds.
// Go/done handshake, abort, sticky overflow and optional saturation with early exit.
module fib_gen #(
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    abort,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;
  logic [INPUT_WIDTH-1:0]  i_q, i_d;
  logic [OUTPUT_WIDTH-1:0] x_q, x_d;
  logic [OUTPUT_WIDTH-1:0] y_q, y_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic                    setup_q, setup_d;
  logic [OUTPUT_WIDTH:0]   sum;

  assign sum = {1'b0, x_q} + {1'b0, y_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    setup_d  = setup_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (go) begin
          n_d     = n;
          x_d     = seed0;
          y_d     = seed1;
          i_d     = INPUT_WIDTH'(1);
          ovf_d   = 1'b0;
          done_d  = 1'b0;
          setup_d = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (abort) begin
          // Abort wins over everything else; result keeps its previous value.
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          setup_d = 1'b0;
          state_d = StIdle;
        end else if (setup_q) begin
          // First CALC cycle only settles the captured operands; steps start next edge.
          setup_d = 1'b0;
        end else if (i_q >= n_q) begin
          result_d = (n_q == '0) ? x_q : y_q;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (sum[OUTPUT_WIDTH] && (SATURATE != 0)) begin
          ovf_d    = 1'b1;
          result_d = '1;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          if (sum[OUTPUT_WIDTH]) begin
            ovf_d = 1'b1;
          end
          x_d = y_q;
          y_d = sum[OUTPUT_WIDTH-1:0];
          i_d = i_q + INPUT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      n_q      <= '0;
      i_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      setup_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      setup_q  <= setup_d;
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == StCalc);
  assign done     = done_q;

endmodule
